regwr_rr_arbiter: RTL and testbench

//   Round-robin arbiter sharing the single write port of the CPU register bank
//   (an array of reset-able D registers) between N_REQ requesters (ALU

---
 rtl/regwr_rr_arbiter_pkg.sv | 9 +
 rtl/regwr_rr_arbiter_rr_pick.sv | 33 +++
 rtl/regwr_rr_arbiter.sv | 67 ++++++
 tb/tb_regwr_rr_arbiter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/regwr_rr_arbiter_pkg.sv
// Shared constants for the register-bank write-port arbiter.
// Word size, register index width and requester-count limit.
package regwr_rr_arbiter_pkg;

  localparam int WORD_LENGTH = 32;
  localparam int REG_ADDR_W  = 3;
  localparam int RR_MAX_REQ  = 8;

endpackage

// File: rtl/regwr_rr_arbiter_rr_pick.sv
// Combinational round-robin pick.
// Rotate so ptr sits at bit 0, take the lowest set bit, rotate the index back.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);

  localparam logic [PW:0] NV = (PW+1)'(N);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [PW-1:0]  off;
  logic [PW:0]    sum;

  always_comb begin
    dbl = {req, req};
    rot = dbl[ptr +: N];
    off = '0;
    for (int j = N-1; j >= 0; j--) begin
      if (rot[j]) off = PW'(j);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= NV) sum = sum - NV;
    idx = sum[PW-1:0];
    gnt = (|req) ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/regwr_rr_arbiter.sv
// Round-robin arbiter for the register bank's single write port,
// with a one-entry output stage that honours a stall from the bank.
module regwr_rr_arbiter
  import regwr_rr_arbiter_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int WIDTH  = WORD_LENGTH,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int PW     = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*WIDTH-1:0]  req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    wr_en,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [WIDTH-1:0]        wr_data,
  input  logic                    wr_stall,
  output logic [PW-1:0]           grant_id
);

  if (N_REQ < 2 || N_REQ > RR_MAX_REQ) begin : g_chk
    $error("regwr_rr_arbiter: N_REQ out of range");
  end

  logic [PW-1:0]    ptr;
  logic [N_REQ-1:0] gnt;
  logic [PW-1:0]    idx;
  logic             stage_free;
  logic             hs;

  rr_pick #(
    .N  (N_REQ),
    .PW (PW)
  ) u_pick (
    .req (req_valid),
    .ptr (ptr),
    .gnt (gnt),
    .idx (idx)
  );

  assign stage_free = !wr_en || !wr_stall;
  assign req_ready  = (stage_free && rst_n) ? gnt : '0;
  assign hs         = |req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      grant_id <= '0;
    end else if (hs) begin
      wr_en    <= 1'b1;
      wr_addr  <= req_addr[idx*ADDR_W +: ADDR_W];
      wr_data  <= req_data[idx*WIDTH +: WIDTH];
      grant_id <= idx;
      ptr      <= (idx == PW'(N_REQ-1)) ? '0 : idx + 1'b1;
    end else if (stage_free) begin
      // stage retired (or was empty) with nothing new to load
      wr_en <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regwr_rr_arbiter.sv
// Directed vector bench for regwr_rr_arbiter (N_REQ=4, 32-bit data).
// Table-driven rotation/stall/fairness plus hand sequences for single and reset.
module tb_regwr_rr_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int AW = 3;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*W-1:0]  req_data;
  logic [N-1:0]  req_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          wr_stall;
  logic [1:0]    grant_id;

  int n_chk;
  int n_fail;

  regwr_rr_arbiter #(
    .N_REQ  (N),
    .WIDTH  (W),
    .ADDR_W (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_stall  (wr_stall),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] valid;
    logic       stall;
    logic [3:0] ready;
    logic       en;
    logic [1:0] gid;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] dflt_data(input logic [1:0] i);
    return 32'hC0DE_0000 | W'(i);
  endfunction

  initial begin
    clk = 0;
    rst_n = 0;
    n_chk = 0;
    n_fail = 0;
    wr_stall = 0;
    req_valid = 4'b1111;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = AW'(i + 1);
      req_data[i*W +: W]   = dflt_data(2'(i));
    end

    // rotation, stall, idle, stall-on-empty, fairness
    vecs[0]  = '{4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0};
    vecs[1]  = '{4'b1111, 1'b0, 4'b0010, 1'b1, 2'd1};
    vecs[2]  = '{4'b1111, 1'b0, 4'b0100, 1'b1, 2'd2};
    vecs[3]  = '{4'b1111, 1'b0, 4'b1000, 1'b1, 2'd3};
    vecs[4]  = '{4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0};
    vecs[5]  = '{4'b1111, 1'b0, 4'b0010, 1'b1, 2'd1};
    vecs[6]  = '{4'b1111, 1'b0, 4'b0100, 1'b1, 2'd2};
    vecs[7]  = '{4'b1111, 1'b0, 4'b1000, 1'b1, 2'd3};
    vecs[8]  = '{4'b1111, 1'b1, 4'b0000, 1'b1, 2'd3};
    vecs[9]  = '{4'b1111, 1'b1, 4'b0000, 1'b1, 2'd3};
    vecs[10] = '{4'b1111, 1'b1, 4'b0000, 1'b1, 2'd3};
    vecs[11] = '{4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0};
    vecs[12] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0};
    vecs[13] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
    vecs[14] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0};
    vecs[15] = '{4'b1001, 1'b0, 4'b1000, 1'b1, 2'd3};
    vecs[16] = '{4'b1001, 1'b0, 4'b0001, 1'b1, 2'd0};
    vecs[17] = '{4'b1001, 1'b0, 4'b1000, 1'b1, 2'd3};
    vecs[18] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd3};

    #12;
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    check("rst_wr_data", 64'(wr_data), 64'd0);
    check("rst_grant_id", 64'(grant_id), 64'd0);

    @(posedge clk);
    #1;
    rst_n = 1;

    for (int i = 0; i < 19; i++) begin
      req_valid = vecs[i].valid;
      wr_stall  = vecs[i].stall;
      #1;
      check($sformatf("v%0d_ready", i), 64'(req_ready), 64'(vecs[i].ready));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_wr_en", i), 64'(wr_en), 64'(vecs[i].en));
      check($sformatf("v%0d_gid", i), 64'(grant_id), 64'(vecs[i].gid));
      check($sformatf("v%0d_addr", i), 64'(wr_addr),
            64'(AW'(vecs[i].gid) + AW'(1)));
      check($sformatf("v%0d_data", i), 64'(wr_data),
            64'(dflt_data(vecs[i].gid)));
    end

    // single request from requester 2
    req_addr[2*AW +: AW] = 3'd5;
    req_data[2*W +: W]   = 32'hDEADBEEF;
    req_valid = 4'b0100;
    wr_stall  = 0;
    #1;
    check("single_ready", 64'(req_ready), 64'b0100);
    @(posedge clk);
    #1;
    check("single_wr_en", 64'(wr_en), 64'd1);
    check("single_addr", 64'(wr_addr), 64'd5);
    check("single_data", 64'(wr_data), 64'hDEADBEEF);
    check("single_gid", 64'(grant_id), 64'd2);

    // reset while a write is held in the output stage
    req_valid = 4'b0000;
    wr_stall  = 1;
    #1;
    rst_n = 0;
    #1;
    check("midrst_wr_en", 64'(wr_en), 64'd0);
    check("midrst_addr", 64'(wr_addr), 64'd0);
    check("midrst_data", 64'(wr_data), 64'd0);
    check("midrst_gid", 64'(grant_id), 64'd0);
    req_valid = 4'b1111;
    #1;
    check("midrst_ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    check("midrst_hold_en", 64'(wr_en), 64'd0);
    rst_n = 1;
    wr_stall = 0;
    #1;
    check("postrst_ready", 64'(req_ready), 64'b0001);
    @(posedge clk);
    #1;
    check("postrst_wr_en", 64'(wr_en), 64'd1);
    check("postrst_gid", 64'(grant_id), 64'd0);
    req_valid = 4'b0000;
    @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
